// File: rtl/relu_maxpool22.sv
// ============================================================================
// Module      : relu_maxpool22
// Description : Streaming 2x2/stride-2 max-pool over a raster conv map using a
//               half-width line buffer. Optional ReLU clamp under POOL_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_maxpool22 #(
    parameter int OUT_WIDTH = 32,
    parameter int IMG_W     = 10,
    parameter int IMG_H     = 10,
    parameter int CW        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_col,
    output logic [CW-1:0]        out_row,
    output logic                 frame_done
);

    localparam int            c_half_w   = IMG_W / 2;
    localparam int            c_lbw      = (c_half_w > 1) ? $clog2(c_half_w) : 1;
    localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_last_row = CW'(IMG_H - 1);

    logic [CW-1:0]               r_col;
    logic [CW-1:0]               r_row;
    logic signed [OUT_WIDTH-1:0] r_pair;
    logic signed [OUT_WIDTH-1:0] r_linebuf [c_half_w];

    logic                        r_out_valid;
    logic [OUT_WIDTH-1:0]        r_out_data;
    logic [CW-1:0]               r_out_col;
    logic [CW-1:0]               r_out_row;
    logic                        r_frame_done;

    logic signed [OUT_WIDTH-1:0] w_in;
    logic signed [OUT_WIDTH-1:0] w_hmax;
    logic signed [OUT_WIDTH-1:0] w_lb_rd;
    logic signed [OUT_WIDTH-1:0] w_vmax;
    logic signed [OUT_WIDTH-1:0] w_result;
    logic [CW-1:0]               w_col_half;
    logic [CW-1:0]               w_row_half;
    logic [c_lbw-1:0]            w_lb_idx;
    logic                        w_pair_done;
    logic                        w_lb_write;
    logic                        w_emit;
    logic                        w_last_pix;

    assign w_in        = $signed(in_data);
    assign w_col_half  = r_col >> 1;
    assign w_row_half  = r_row >> 1;
    assign w_lb_idx    = w_col_half[c_lbw-1:0];
    assign w_pair_done = in_valid & r_col[0];
    assign w_lb_write  = w_pair_done & ~r_row[0];
    assign w_emit      = w_pair_done & r_row[0];
    assign w_last_pix  = (r_col == c_last_col) && (r_row == c_last_row);

    assign w_hmax  = (r_pair > w_in) ? r_pair : w_in;
    assign w_lb_rd = r_linebuf[w_lb_idx];
    assign w_vmax  = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

`ifdef POOL_RELU_EN
    // Clamping after the max is equivalent to clamping each operand first.
    assign w_result = w_vmax[OUT_WIDTH-1] ? '0 : w_vmax;
`else
    assign w_result = w_vmax;
`endif

    // Raster position of the next accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (r_col == c_last_col) begin
                r_col <= '0;
                r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair <= '0;
        end else if (in_valid && !r_col[0]) begin
            r_pair <= w_in;
        end
    end

    // Even rows park their horizontal max; the odd row below consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_half_w; i++) begin
                r_linebuf[i] <= '0;
            end
        end else if (w_lb_write) begin
            r_linebuf[w_lb_idx] <= w_hmax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_emit) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_result;
                r_out_col    <= w_col_half;
                r_out_row    <= w_row_half;
                r_frame_done <= w_last_pix;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_col    = r_out_col;
    assign out_row    = r_out_row;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool22.sv
// ============================================================================
// Module      : tb_relu_maxpool22
// Description : Directed/randomized bench for relu_maxpool22 against a
//               frame-array window model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relu_maxpool22;

    localparam int W   = 32;
    localparam int IW  = 10;
    localparam int IH  = 10;
    localparam int CWP = 4;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data  = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CWP-1:0] out_col;
    logic [CWP-1:0] out_row;
    logic           frame_done;

    relu_maxpool22 #(
        .OUT_WIDTH (W),
        .IMG_W     (IW),
        .IMG_H     (IH),
        .CW        (CWP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_row    (out_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int                 n_cmp = 0;
    int                 n_fail = 0;
    int                 m_row = 0;
    int                 m_col = 0;
    int                 fd_cnt = 0;
    int                 fd_total = 0;
    logic signed [W-1:0] frame_px [IH][IW];
    logic [W-1:0]       hold_data = '0;
    logic [CWP-1:0]     hold_col = '0;
    logic [CWP-1:0]     hold_row = '0;
    logic [W-1:0]       outq [$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pooled value: max of the 2x2 window, optionally clamped at zero.
    function automatic logic [W-1:0] window_ref(input int pr, input int pc);
        longint m, p;
        m = frame_px[2*pr][2*pc];
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                p = frame_px[2*pr+dr][2*pc+dc];
                if (p > m) m = p;
            end
        end
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return W'(m);
    endfunction

    task automatic step(input bit v, input logic [W-1:0] d);
        bit done_win;
        int pr, pc;
        pr = 0;
        pc = 0;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (v) frame_px[m_row][m_col] = d;
        done_win = v && (m_row % 2 == 1) && (m_col % 2 == 1);
        @(posedge clk);
        #1;
        if (done_win) begin
            pr        = m_row / 2;
            pc        = m_col / 2;
            hold_data = window_ref(pr, pc);
            hold_col  = CWP'(pc);
            hold_row  = CWP'(pr);
        end
        chk("out_valid", W'(out_valid), W'(done_win));
        chk("out_data", out_data, hold_data);
        chk("out_col", W'(out_col), W'(hold_col));
        chk("out_row", W'(out_row), W'(hold_row));
        chk("frame_done", W'(frame_done), W'(done_win && pr == IH/2-1 && pc == IW/2-1));
        if (out_valid) outq.push_back(out_data);
        if (frame_done) begin
            fd_cnt++;
            fd_total++;
        end
        if (v) begin
            if (m_col == IW-1) begin
                m_col = 0;
                m_row = (m_row == IH-1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_col", W'(out_col), '0);
        chk("rst_out_row", W'(out_row), '0);
        chk("rst_frame_done", W'(frame_done), '0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        m_row     = 0;
        m_col     = 0;
        hold_data = '0;
        hold_col  = '0;
        hold_row  = '0;
    endtask

    // mode 0: ramp 10*r+c+off, 1: random, 2: random with two directed windows
    function automatic logic [W-1:0] pix(input int mode, input int r, input int c, input int off);
        if (mode == 0) return W'(10*r + c + off);
        if (mode == 2) begin
            if (r == 0 && c == 0) return 32'hFFFF_FFFB;
            if (r == 0 && c == 1) return 32'hFFFF_FFFD;
            if (r == 1 && c == 0) return 32'hFFFF_FFF8;
            if (r == 1 && c == 1) return 32'hFFFF_FFF9;
            if (r == 0 && c == 2) return 32'h8000_0000;
            if (r == 0 && c == 3) return 32'h7FFF_FFFF;
            if (r == 1 && (c == 2 || c == 3)) return 32'h0;
        end
        return $urandom;
    endfunction

    task automatic feed_frame(input int mode, input int off, input int gap_pct, input int npix);
        outq.delete();
        fd_cnt = 0;
        for (int k = 0; k < npix; k++) begin
            while ($urandom_range(0, 99) < gap_pct) step(1'b0, $urandom);
            step(1'b1, pix(mode, k / IW, k % IW, off));
        end
    endtask

    task automatic chk_ramp(input string tag, input int off);
        chk({tag, "_count"}, W'(outq.size()), W'(25));
        chk({tag, "_fd_count"}, W'(fd_cnt), W'(1));
        if (outq.size() == 25) begin
            chk({tag, "_first"}, outq[0], W'(11 + off));
            chk({tag, "_last"}, outq[24], W'(99 + off));
        end
    endtask

    initial begin
        do_reset();
        repeat (3) step(1'b0, 32'hDEAD_BEEF);

        feed_frame(0, 0, 0, IW*IH);
        chk_ramp("ramp", 0);
        repeat (2) step(1'b0, $urandom);

        feed_frame(0, 0, 50, IW*IH);
        chk_ramp("gapped", 0);

        fd_total = 0;
        feed_frame(0, 0, 0, IW*IH);
        chk_ramp("b2b_a", 0);
        feed_frame(0, 1000, 0, IW*IH);
        chk_ramp("b2b_b", 1000);
        chk("b2b_fd_total", W'(fd_total), W'(2));

        feed_frame(2, 0, 0, IW*IH);
        if (outq.size() >= 2) begin
`ifdef POOL_RELU_EN
            chk("neg_window", outq[0], 32'h0);
`else
            chk("neg_window", outq[0], 32'hFFFF_FFFD);
`endif
            chk("extreme_window", outq[1], 32'h7FFF_FFFF);
        end else begin
            chk("neg_count", W'(outq.size()), W'(25));
        end

        repeat (3) feed_frame(1, 0, 30, IW*IH);

        feed_frame(0, 0, 0, 37);
        do_reset();
        repeat (3) step(1'b0, $urandom);
        feed_frame(0, 0, 0, IW*IH);
        chk_ramp("post_reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
